// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if: operand-read (rd_*/rs*), operand-return (op_*) and writeback (wb_*) bus; master = pipeline, slave = controller
interface regfile_port_ctrl_if #(parameter int DATA_W = 64, parameter int ADDR_W = 5);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  modport master (
    output rd_valid, rs1, rs2, op_ready, wb_valid, wb_reg, wb_data,
    input  rd_ready, op_valid, op_a, op_b
  );
  modport slave (
    input  rd_valid, rs1, rs2, op_ready, wb_valid, wb_reg, wb_data,
    output rd_ready, op_valid, op_a, op_b
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: regfile read/write port controller with writeback forwarding; ports clk, reset, bus (slave), ReadRegister1/2, ReadData1/2, WriteRegister, WriteData, RegWrite
module regfile_port_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_port_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0]   ReadRegister1,
  output logic [ADDR_W-1:0]   ReadRegister2,
  input  logic [DATA_W-1:0]   ReadData1,
  input  logic [DATA_W-1:0]   ReadData2,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData,
  output logic                RegWrite
);
  localparam logic [ADDR_W-1:0] XZR = '1;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic we_q, accept;
  logic [DATA_W-1:0] src_a, src_b;
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rdata,
    input logic              wv,
    input logic [ADDR_W-1:0] wr,
    input logic [DATA_W-1:0] wd,
    input logic              pv,
    input logic [ADDR_W-1:0] pr,
    input logic [DATA_W-1:0] pd
  );
    return idx == XZR ? '0 : (wv && wr == idx) ? wd : (pv && pr == idx) ? pd : rdata;
  endfunction
  assign ReadRegister1 = bus.rs1;
  assign ReadRegister2 = bus.rs2;
  // a pending write is dropped at the reset edge, so the regfile must not see it
  assign RegWrite = we_q && !reset;
  assign bus.op_valid = state == FULL;
  assign bus.rd_ready = state == EMPTY || bus.op_ready;
  assign accept = bus.rd_valid && bus.rd_ready;
  assign src_a = fwd(bus.rs1, ReadData1, bus.wb_valid, bus.wb_reg, bus.wb_data, RegWrite, WriteRegister, WriteData);
  assign src_b = fwd(bus.rs2, ReadData2, bus.wb_valid, bus.wb_reg, bus.wb_data, RegWrite, WriteRegister, WriteData);
  always_comb state_nx = accept ? FULL : bus.op_ready ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      bus.op_a      <= '0;
      bus.op_b      <= '0;
      we_q          <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      state         <= state_nx;
      we_q          <= bus.wb_valid && bus.wb_reg != XZR;
      WriteRegister <= bus.wb_reg;
      WriteData     <= bus.wb_data;
      if (accept) begin
        bus.op_a <= src_a;
        bus.op_b <= src_b;
      end
    end
  end
endmodule
